pio_tx_arbiter: RTL



---
 rtl/pio_pkg.sv | 24 ++
 rtl/pio_tx_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pio_pkg.sv
// Shared types and constants for the PIO TX path: arbiter state encoding,
// source indices and the beat bundle carried on the 64-bit AXI4-Stream.
package pio_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CPL   = 3'd1,
        REQ   = 3'd2,
        ABORT = 3'd3,
        OFF   = 3'd4
    } state_e;

    localparam logic       SRC_CPL    = 1'b0;
    localparam logic       SRC_REQ    = 1'b1;
    localparam logic [7:0] TKEEP_FULL = 8'hFF;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
        logic        tvalid;
    } axis_beat_t;

endpackage

// File: rtl/pio_tx_arbiter.sv
// Packet-atomic two-source arbiter onto the endpoint TX stream, with stall
// abort (tx_src_dsc plus flush of the stalled source) and turnoff handshake.
module pio_tx_arbiter
    import pio_pkg::*;
#(
    parameter int STALL_TIMEOUT = 64,
    parameter bit CPL_PRIORITY  = 1'b0
) (
    input  logic        user_clk,
    input  logic        user_reset,
    input  logic        user_lnk_up,

    input  logic [63:0] cpl_tdata,
    input  logic [7:0]  cpl_tkeep,
    input  logic        cpl_tlast,
    input  logic        cpl_tvalid,
    output logic        cpl_tready,

    input  logic [63:0] req_tdata,
    input  logic [7:0]  req_tkeep,
    input  logic        req_tlast,
    input  logic        req_tvalid,
    output logic        req_tready,

    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    input  logic        s_axis_tx_tready,
    output logic        tx_src_dsc,

    input  logic        cfg_to_turnoff,
    output logic        cfg_turnoff_ok
);

    localparam int              CNT_W      = $clog2(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             flush_cpl_q, flush_cpl_d;
    logic             flush_req_q, flush_req_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             turnoff_ok_q, turnoff_ok_d;

    axis_beat_t cpl_beat, req_beat, gnt_beat, out_beat;
    logic       cpl_eligible, req_eligible, pick_cpl;
    logic       abort_start;

    assign cpl_beat = '{tdata: cpl_tdata, tkeep: cpl_tkeep, tlast: cpl_tlast, tvalid: cpl_tvalid};
    assign req_beat = '{tdata: req_tdata, tkeep: req_tkeep, tlast: req_tlast, tvalid: req_tvalid};

    // A source still draining an aborted TLP is never offered a new grant.
    assign cpl_eligible = cpl_tvalid & ~flush_cpl_q;
    assign req_eligible = req_tvalid & ~flush_req_q;

    always_comb begin
        if (CPL_PRIORITY) begin
            pick_cpl = cpl_eligible;
        end else begin
            pick_cpl = cpl_eligible & (~req_eligible | (last_grant_q == SRC_REQ));
        end
    end

    // Zero-latency data path: the granted source is muxed straight through.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement leaves a latch behind.
        gnt_beat   = '0;
        out_beat   = '0;
        tx_src_dsc = 1'b0;
        unique case (state_q)
            CPL:     gnt_beat = cpl_beat;
            REQ:     gnt_beat = req_beat;
            default: gnt_beat = '0;
        endcase
        out_beat = gnt_beat;
        if (state_q == ABORT) begin
            out_beat   = '{tdata: '0, tkeep: TKEEP_FULL, tlast: 1'b1, tvalid: 1'b1};
            tx_src_dsc = 1'b1;
        end
    end

    assign s_axis_tx_tdata  = out_beat.tdata;
    assign s_axis_tx_tkeep  = out_beat.tkeep;
    assign s_axis_tx_tlast  = out_beat.tlast;
    assign s_axis_tx_tvalid = out_beat.tvalid;

    assign cpl_tready = flush_cpl_q | ((state_q == CPL) & s_axis_tx_tready);
    assign req_tready = flush_req_q | ((state_q == REQ) & s_axis_tx_tready);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        stall_cnt_d  = '0;
        abort_start  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_to_turnoff) begin
                    state_d = OFF;
                end else if (user_lnk_up && (cpl_eligible || req_eligible)) begin
                    state_d = pick_cpl ? CPL : REQ;
                end
            end
            CPL, REQ: begin
                // An offered beat always beats the timeout, even on the last count.
                if (gnt_beat.tvalid) begin
                    if (s_axis_tx_tready && gnt_beat.tlast) begin
                        state_d      = IDLE;
                        last_grant_d = (state_q == CPL) ? SRC_CPL : SRC_REQ;
                    end
                end else if (stall_cnt_q == STALL_LAST) begin
                    state_d     = ABORT;
                    abort_start = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
            ABORT: begin
                if (s_axis_tx_tready) begin
                    state_d = IDLE;
                end
            end
            OFF: begin
                if (!cfg_to_turnoff) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush runs independently of the FSM and ends on the source's own tlast.
    always_comb begin
        flush_cpl_d = flush_cpl_q;
        flush_req_d = flush_req_q;
        if (flush_cpl_q && cpl_tvalid && cpl_tlast) begin
            flush_cpl_d = 1'b0;
        end
        if (flush_req_q && req_tvalid && req_tlast) begin
            flush_req_d = 1'b0;
        end
        if (abort_start && (state_q == CPL)) begin
            flush_cpl_d = 1'b1;
        end
        if (abort_start && (state_q == REQ)) begin
            flush_req_d = 1'b1;
        end
    end

    assign turnoff_ok_d   = (state_d == OFF);
    assign cfg_turnoff_ok = turnoff_ok_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_REQ;
            flush_cpl_q  <= 1'b0;
            flush_req_q  <= 1'b0;
            stall_cnt_q  <= '0;
            turnoff_ok_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            flush_cpl_q  <= flush_cpl_d;
            flush_req_q  <= flush_req_d;
            stall_cnt_q  <= stall_cnt_d;
            turnoff_ok_q <= turnoff_ok_d;
        end
    end

endmodule
